// File: rtl/flags_gen_pkg.sv
// Shared condition-flag definitions: flag bundle and the flag operation classes.
package flags_gen_pkg;

  typedef struct packed {
    logic ZF;
    logic SF;
    logic CF;
    logic OF;
  } FLAGS_t;

  typedef enum logic [2:0] {
    FOP_NONE  = 3'd0,
    FOP_ADD   = 3'd1,
    FOP_SUB   = 3'd2,
    FOP_CMP   = 3'd3,
    FOP_LOGIC = 3'd4,
    FOP_INC   = 3'd5,
    FOP_DEC   = 3'd6,
    FOP_PASS  = 3'd7
  } FLAG_OP_t;

endpackage

// File: rtl/flags_gen_if.sv
// Execute-stage to flag-producer interface; master drives operands, slave returns flags.
interface flags_gen_if
  import flags_gen_pkg::*;
#(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             set_flags;
  FLAG_OP_t         op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  FLAGS_t           restore_flags;
  logic             stall;
  logic             flush;
  FLAGS_t           flags;
  FLAGS_t           flags_committed;
  logic             pending;

  modport master (
    output in_valid, set_flags, op, a, b, restore_flags, stall, flush,
    input  flags, flags_committed, pending
  );

  modport slave (
    input  in_valid, set_flags, op, a, b, restore_flags, stall, flush,
    output flags, flags_committed, pending
  );
endinterface

// File: rtl/flags_gen_calc.sv
// Combinational ZF/SF/CF/OF computation from operation class, operands and the CF to preserve.
module flags_calc
  import flags_gen_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  FLAG_OP_t         op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  FLAGS_t           restore_flags,
  input  logic             cf_in,
  output FLAGS_t           flags_out
);

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] r;
  logic             cf;
  logic             of;

  always_comb begin
    sum       = '0;
    r         = '0;
    cf        = 1'b0;
    of        = 1'b0;
    flags_out = '0;
    unique case (op)
      FOP_ADD: begin
        sum = {1'b0, a} + {1'b0, b};
        r   = sum[WIDTH-1:0];
        cf  = sum[WIDTH];
        of  = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      FOP_SUB, FOP_CMP: begin
        // Top bit of the extended difference is the unsigned borrow.
        sum = {1'b0, a} - {1'b0, b};
        r   = sum[WIDTH-1:0];
        cf  = sum[WIDTH];
        of  = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      FOP_LOGIC: begin
        r = a & b;
      end
      FOP_INC: begin
        sum = {1'b0, a} + {1'b0, ONE};
        r   = sum[WIDTH-1:0];
        cf  = cf_in;
        of  = (a == MAX_POS);
      end
      FOP_DEC: begin
        sum = {1'b0, a} - {1'b0, ONE};
        r   = sum[WIDTH-1:0];
        cf  = cf_in;
        of  = (a == MIN_NEG);
      end
      default: ;
    endcase

    if (op == FOP_PASS) begin
      flags_out = restore_flags;
    end else if (op != FOP_NONE) begin
      flags_out.ZF = (r == '0);
      flags_out.SF = r[WIDTH-1];
      flags_out.CF = cf;
      flags_out.OF = of;
    end
  end

endmodule

// File: rtl/flags_gen.sv
// Flag producer: one-entry pending flag register retiring into the architectural flag register.
module flags_gen
  import flags_gen_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic       CLK,
  input  logic       rst,
  flags_gen_if.slave bus
);

  logic   pending_q,    pending_d;
  FLAGS_t pend_flags_q, pend_flags_d;
  FLAGS_t comm_flags_q, comm_flags_d;
  FLAGS_t calc_flags;
  logic   cf_newest;
  logic   cap;

  assign cf_newest = pending_q ? pend_flags_q.CF : comm_flags_q.CF;
  assign cap = bus.in_valid && bus.set_flags && !bus.stall && !bus.flush
               && (bus.op != FOP_NONE);

  flags_calc #(
    .WIDTH (WIDTH)
  ) u_calc (
    .op            (bus.op),
    .a             (bus.a),
    .b             (bus.b),
    .restore_flags (bus.restore_flags),
    .cf_in         (cf_newest),
    .flags_out     (calc_flags)
  );

  // Stall freezes all state; flush drops the pending entry without retiring it.
  always_comb begin
    pending_d    = pending_q;
    pend_flags_d = pend_flags_q;
    comm_flags_d = comm_flags_q;
    if (!bus.stall) begin
      if (bus.flush) begin
        pending_d = 1'b0;
      end else begin
        if (pending_q) begin
          comm_flags_d = pend_flags_q;
        end
        pending_d = cap;
        if (cap) begin
          pend_flags_d = calc_flags;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      pending_q    <= 1'b0;
      pend_flags_q <= '0;
      comm_flags_q <= '0;
    end else begin
      pending_q    <= pending_d;
      pend_flags_q <= pend_flags_d;
      comm_flags_q <= comm_flags_d;
    end
  end

  assign bus.flags           = pending_q ? pend_flags_q : comm_flags_q;
  assign bus.flags_committed = comm_flags_q;
  assign bus.pending         = pending_q;

endmodule

// File: doc/flags_gen.md
Name: flags_gen

Overview:
- Producer side of the condition-flag interface.
- Computes ZF/SF/CF/OF from execute-stage operands and holds them in a one-entry pending register. The pending entry retires into an architectural flag register.
- Presents the newest flags (FLAGS_t) to the condition/branch evaluation block.
- Supports pipeline stall, flush and flag restore, so branch/jump evaluation always sees correct flags.

Parameters:
- WIDTH, 32, operand width in bits (minimum 2).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  execute-stage instruction valid this cycle.
- set_flags  input  1  instruction writes flags; ignored unless in_valid.
- op  input  FLAG_OP_t (3)  flag operation class.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- restore_flags  input  FLAGS_t  value loaded when op == FOP_PASS.
- stall  input  1  hold all state; no capture, no commit.
- flush  input  1  discard pending entry.
- flags  output  FLAGS_t  newest flags: pending entry if pending, else committed.
- flags_committed  output  FLAGS_t  architectural flag register.
- pending  output  1  pending entry valid.

Behaviour:
- Reset: while rst is high, pending=0, pending flags=0, committed flags=0. Hence flags=0 and flags_committed=0 asynchronously. Reset mid-operation drops the pending entry without committing it.
- Capture condition: cap = in_valid & set_flags & ~stall & ~flush & (op != FOP_NONE).
- Computation uses an internal WIDTH+1-bit adder. r is the WIDTH-bit result; msb means bit WIDTH-1.
  - FOP_ADD: r=a+b; CF=carry out; OF=(a.msb==b.msb)&(r.msb!=a.msb).
  - FOP_SUB and FOP_CMP (identical flags): r=a-b; CF=borrow (a<b unsigned); OF=(a.msb!=b.msb)&(r.msb!=a.msb).
  - FOP_LOGIC: r=a&b; CF=0; OF=0.
  - FOP_INC: r=a+1; OF=(a==0111..1); CF preserved.
  - FOP_DEC: r=a-1; OF=(a==1000..0); CF preserved.
  - All arithmetic/logic ops: ZF=(r==0); SF=r.msb.
  - FOP_PASS: flags = restore_flags verbatim.
- CF preservation for INC/DEC uses the newest CF (pending entry if valid, else committed), sampled in the capture cycle.
- Latency: flags computed in cycle N appear on flags at N+1 (pending=1). They appear on flags_committed at N+2, provided no stall or flush in N+1.
- Per-cycle update order, priority highest first:
  1. stall=1: hold everything. Stall wins over flush, commit and capture.
  2. Otherwise flush=1: pending<=0; pending entry is never committed; committed flags unchanged; no capture that cycle.
  3. Otherwise:
     - If pending, commit: committed<=pending flags.
     - If cap: pending flags<=computed, pending<=1.
     - Else pending<=0.
- Back-to-back captures are allowed: commit of the old entry and capture of the new one happen in the same edge, so throughput is 1/cycle.
- in_valid with set_flags=0, or op==FOP_NONE, causes no capture; the pending entry still commits.
- The flags output is purely combinational from registers (mux on pending), with no combinational path from a/b/op.

Decomposition:
- Shared package/header alongside the existing flag definitions: FLAGS_t, already defined with fields ZF, SF, CF, OF.
- FLAG_OP_t enum, 3 bits, added to the same package: FOP_NONE=0, FOP_ADD=1, FOP_SUB=2, FOP_CMP=3, FOP_LOGIC=4, FOP_INC=5, FOP_DEC=6, FOP_PASS=7.
- One natural sub-module: flags_calc, a purely combinational computation of FLAGS_t from op, a, b and preserved CF. It is reused by the bench as a reference model.

Test Plan:
1. ADD a=0xFFFFFFFF b=0x1 -> next cycle flags {ZF=1,SF=0,CF=1,OF=0}, pending=1; cycle after, flags_committed identical and pending=0.
2. SUB a=0x80000000 b=0x1 -> flags {ZF=0,SF=0,CF=0,OF=1}. Then CMP a=3 b=5 in the next cycle -> flags {ZF=0,SF=1,CF=1,OF=0}, while flags_committed shows the SUB flags.
3. ADD a=0xFFFFFFFF b=2 (CF=1), then immediately INC a=0x7FFFFFFF -> flags {ZF=0,SF=1,CF=1,OF=1}. DEC a=0x80000000 with CF=0 -> {ZF=0,SF=0,CF=0,OF=1}.
4. Capture ADD 1+1, then stall high 3 cycles -> pending=1 and flags_committed unchanged throughout. Deassert stall -> committed becomes {0,0,0,0} one edge later.
5. Committed {ZF=1}; capture SUB 2-1, then flush -> pending=0, flags returns to {ZF=1,...}, and the SUB flags are never committed. Then PASS with restore_flags {SF=1,OF=1} -> committed {SF=1,OF=1} after 2 cycles.
6. Pending entry valid; assert rst asynchronously mid-cycle -> flags, flags_committed and pending are all 0 before the next CLK edge, and stay 0 until rst drops.
